gpr_wb_arbiter: RTL and testbench

GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

---
 rtl/gpr_wb_arbiter.sv | 82 ++++++++
 tb/tb_gpr_wb_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_arbiter.sv
// Two-source register-file writeback arbiter with round-robin grant, a registered
// write port, a per-register pending-write scoreboard and a saturating conflict counter.
module gpr_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [4:0]        req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [4:0]        req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              rsv_valid,
  input  logic [4:0]        rsv_addr,
  output logic              gpr_we,
  output logic [4:0]        gpr_waddr,
  output logic [DATA_W-1:0] gpr_wdata,
  output logic [31:0]       busy,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // last_q = 1 means source 1 was granted most recently, so source 0 wins the next conflict.
  logic              last_q;
  logic              xfer;
  logic [4:0]        sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [31:0]       busy_d;
  logic [CNT_W-1:0]  cnt_d;

  always_comb begin
    req0_ready = req0_valid && (!req1_valid || last_q);
    req1_ready = req1_valid && (!req0_valid || !last_q);
  end

  assign xfer     = req0_ready || req1_ready;
  assign sel_addr = req0_ready ? req0_addr : req1_addr;
  assign sel_data = req0_ready ? req0_data : req1_data;

  // Set is applied after clear so a reservation on the clearing edge wins.
  always_comb begin
    busy_d = busy;
    if (gpr_we) begin
      busy_d[gpr_waddr] = 1'b0;
    end
    if (rsv_valid) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = conflict_cnt;
    if (req0_valid && req1_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
      cnt_d = conflict_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q       <= 1'b1;
      gpr_we       <= 1'b0;
      gpr_waddr    <= '0;
      gpr_wdata    <= '0;
      busy         <= '0;
      conflict_cnt <= '0;
    end else begin
      gpr_we       <= xfer && (sel_addr != 5'd0);
      busy         <= busy_d;
      conflict_cnt <= cnt_d;
      if (xfer) begin
        last_q    <= req1_ready;
        gpr_waddr <= sel_addr;
        gpr_wdata <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Scoreboard bench for gpr_wb_arbiter: expected writes are queued at grant time and
// compared one cycle later; busy and conflict_cnt follow a small reference model.
module tb_gpr_wb_arbiter;

  localparam int unsigned DataW = 32;
  localparam int unsigned CntW  = 4;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0_valid = 1'b0, req1_valid = 1'b0, rsv_valid = 1'b0;
  logic [4:0]        req0_addr = '0, req1_addr = '0, rsv_addr = '0;
  logic [DataW-1:0]  req0_data = '0, req1_data = '0;
  logic              req0_ready, req1_ready, gpr_we;
  logic [4:0]        gpr_waddr;
  logic [DataW-1:0]  gpr_wdata;
  logic [31:0]       busy;
  logic [CntW-1:0]   conflict_cnt;

  int checks = 0;
  int errors = 0;

  exp_t        sb[$];
  logic        m_last;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_busy;
  int          m_cnt;

  gpr_wb_arbiter #(.DATA_W(DataW), .CNT_W(CntW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .busy(busy), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = 1'b1;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_busy  = '0;
    m_cnt   = 0;
    sb.delete();
  endtask

  // Asynchronous reset: outputs are checked before any clock edge occurs.
  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsv_valid  = 1'b0;
    rst_n      = 1'b0;
    #1;
    model_reset();
    chk("rst_we", 32'(gpr_we), 32'(m_we));
    chk("rst_waddr", 32'(gpr_waddr), 32'(m_waddr));
    chk("rst_wdata", gpr_wdata, m_wdata);
    chk("rst_busy", busy, m_busy);
    chk("rst_cnt", 32'(conflict_cnt), 32'(m_cnt));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic rv, input logic [4:0] ra);
    logic        g0, g1;
    logic [31:0] nb;
    exp_t        e;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    rsv_valid  = rv; rsv_addr  = ra;
    #1;
    g0 = v0 && (!v1 || m_last);
    g1 = v1 && !g0;
    chk("ready0", 32'(req0_ready), 32'(g0));
    chk("ready1", 32'(req1_ready), 32'(g1));
    e.we   = (g0 && a0 != 5'd0) || (g1 && a1 != 5'd0);
    e.addr = g0 ? a0 : (g1 ? a1 : m_waddr);
    e.data = g0 ? d0 : (g1 ? d1 : m_wdata);
    sb.push_back(e);
    if (g0 || g1) m_last = g1;
    nb = m_busy;
    if (m_we) nb[m_waddr] = 1'b0;
    if (rv && ra != 5'd0) nb[ra] = 1'b1;
    m_busy = nb;
    if (v0 && v1 && m_cnt < 15) m_cnt++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    m_we = e.we; m_waddr = e.addr; m_wdata = e.data;
    chk("gpr_we", 32'(gpr_we), 32'(e.we));
    chk("gpr_waddr", 32'(gpr_waddr), 32'(e.addr));
    chk("gpr_wdata", gpr_wdata, e.data);
    chk("busy", busy, m_busy);
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
  endtask

  task automatic idle(input logic rv, input logic [4:0] ra);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, rv, ra);
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // Single source on req0.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("single_we", 32'(gpr_we), 32'h1);
    chk("single_data", gpr_wdata, 32'hDEADBEEF);

    // Round-robin after reset: grants 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b1, 5'(i + 10), 32'h200 + 32'(i), 1'b0, 5'd0);
      chk("rr_addr", 32'(gpr_waddr), (i % 2 == 0) ? 32'(i + 1) : 32'(i + 10));
    end
    chk("rr_cnt4", 32'(conflict_cnt), 32'd4);

    // x0 on req1: granted, no write, busy untouched.
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
    chk("x0_we", 32'(gpr_we), 32'h0);

    // Scoreboard set/clear and set-wins collision.
    idle(1'b1, 5'd7);
    chk("sb_set7", 32'(busy[7]), 32'h1);
    step(1'b1, 5'd7, 32'hA5A5_0007, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    idle(1'b0, 5'd0);
    chk("sb_clr7", 32'(busy[7]), 32'h0);
    idle(1'b1, 5'd7);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h7777, 1'b0, 5'd0);
    idle(1'b1, 5'd7);
    chk("sb_collide7", 32'(busy[7]), 32'h1);
    idle(1'b1, 5'd7);
    chk("sb_redundant7", 32'(busy[7]), 32'h1);
    idle(1'b1, 5'd0);
    chk("sb_x0", 32'(busy[0]), 32'h0);

    // Saturation with a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 5'd3, 32'(i), 1'b1, 5'd4, 32'(i) + 32'h1000, 1'b0, 5'd0);
    end
    chk("sat_cnt", 32'(conflict_cnt), 32'd15);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    // Reset mid-stream: grant, then reset while the write is presented.
    idle(1'b1, 5'd9);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9999, 1'b0, 5'd0);
    chk("pre_rst_we", 32'(gpr_we), 32'h1);
    do_reset();
    step(1'b1, 5'd12, 32'hC0DE, 1'b1, 5'd13, 32'hBEEF, 1'b0, 5'd0);
    chk("post_rst_grant0", 32'(gpr_waddr), 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got %0d exp %0d", 0, 1);
    $fatal(1);
  end

endmodule
